vga_sync_gen: RTL and testbench

- Generates 640x480@60 VGA timing from the 100 MHz board clock.
- Drives the x/y pixel coordinates and video_on flag consumed by the clock-face pixel generator.
- Registers and blanks that generator's 12-bit RGB return path toward the VGA connector.
- Sits between the top level, the pixel generator and the Basys3 VGA pins.

---
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480@60 VGA timing generator. Divides the 100 MHz system
//            clock down to a 25 MHz pixel strobe, runs the horizontal and
//            vertical counters, and registers the coordinate, blanking and
//            sync decodes. Also registers and blanks the 12-bit RGB colour
//            returned by the pixel generator before it reaches the VGA pins.
// Ports    : clk         - 100 MHz system clock (only clock)
//            rst_n       - asynchronous active-low reset
//            rgb_in      - {R,G,B} 4:4:4 colour from the pixel generator
//            p_tick      - one-clk pulse at each pixel boundary
//            x, y        - current horizontal / vertical count
//            video_on    - high inside the visible 640x480 area
//            hsync/vsync - active-low sync pulses
//            frame_start - one-clk pulse when counters wrap to (0,0)
//            rgb_out     - registered, blanked colour
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [11:0] rgb_out
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP     = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic               r_p_tick;
    logic               r_frame_start;
    logic               r_video_on;
    logic               r_hsync;
    logic               r_vsync;
    logic [11:0]        r_rgb_out;

    logic               w_tick;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;

    // The counters and every decode move on the same edge that raises
    // p_tick, so the decodes are computed from the next counter values and
    // are valid for the whole pixel period that follows.
    assign w_tick   = (r_div_cnt == c_DIV_LAST);
    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_v_wrap = (r_v_cnt == c_V_LAST);
    assign w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    assign w_v_next = w_h_wrap ? (w_v_wrap ? 10'd0 : r_v_cnt + 10'd1) : r_v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_p_tick      <= 1'b0;
            r_frame_start <= 1'b0;
            // Decode of (0,0): visible, both syncs inactive.
            r_video_on    <= 1'b1;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb_out     <= 12'h000;
        end else begin
            r_div_cnt     <= w_tick ? '0 : r_div_cnt + c_DIV_ONE;
            r_p_tick      <= w_tick;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_h_cnt    <= w_h_next;
                r_v_cnt    <= w_v_next;
                r_video_on <= (w_h_next < c_H_DISP) && (w_v_next < c_V_DISP);
                r_hsync    <= !((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST));
                r_vsync    <= !((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST));
            end
            // One-clk register absorbs the pixel generator's ROM latency.
            r_rgb_out <= r_video_on ? rgb_in : 12'h000;
        end
    end

    assign p_tick      = r_p_tick;
    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign rgb_out     = r_rgb_out;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Directed self-checking bench for vga_sync_gen. A full-size
//            instance covers pixel strobe, line timing, hsync, RGB path and
//            asynchronous reset; a reduced-geometry instance covers frame
//            wrap, vsync and frame_start within a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic        clk;
    logic        r_rst_n;
    logic [11:0] r_rgb_in;

    logic        w_p_tick, w_video_on, w_hsync, w_vsync, w_frame_start;
    logic [9:0]  w_x, w_y;
    logic [11:0] w_rgb_out;

    logic        s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
    logic [9:0]  s_x, s_y;
    logic [11:0] s_rgb_out;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    vga_sync_gen u_dut (
        .clk         (clk),
        .rst_n       (r_rst_n),
        .rgb_in      (r_rgb_in),
        .p_tick      (w_p_tick),
        .x           (w_x),
        .y           (w_y),
        .video_on    (w_video_on),
        .hsync       (w_hsync),
        .vsync       (w_vsync),
        .frame_start (w_frame_start),
        .rgb_out     (w_rgb_out)
    );

    // Small geometry: H_TOTAL = 15, V_TOTAL = 8, 2 clks per pixel.
    // hsync low for h in 10..12, vsync low for v in 5..6.
    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) u_small (
        .clk         (clk),
        .rst_n       (r_rst_n),
        .rgb_in      (r_rgb_in),
        .p_tick      (s_p_tick),
        .x           (s_x),
        .y           (s_y),
        .video_on    (s_video_on),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .frame_start (s_frame_start),
        .rgb_out     (s_rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk edge, then sample 1 ns later; edge_n counts edges since release.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    initial begin
        logic [11:0] v_rgb;
        int hs_low, hs_first, vs_low, vs_first, fs_cnt, fs_first;

        r_rst_n  = 1'b0;
        r_rgb_in = 12'hF00;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_x",        w_x, 0);
        check("rst_y",        w_y, 0);
        check("rst_video_on", w_video_on, 1);
        check("rst_hsync",    w_hsync, 1);
        check("rst_vsync",    w_vsync, 1);
        check("rst_p_tick",   w_p_tick, 0);
        check("rst_fs",       w_frame_start, 0);
        check("rst_rgb_out",  w_rgb_out, 12'h000);

        @(negedge clk);
        r_rst_n = 1'b1;
        edge_n  = 0;

        // First 20 clks: p_tick at 4,8,..; x steps every 4 clks; rgb_out
        // follows a changing rgb_in by one clk.
        for (int k = 1; k <= 20; k++) begin
            v_rgb    = 12'(k * 151 + 7);
            r_rgb_in = v_rgb;
            tick();
            check("start_p_tick", w_p_tick, (k % 4 == 0) ? 1 : 0);
            check("start_x",      w_x, k / 4);
            check("rgb_follow",   w_rgb_out, v_rgb);
        end
        check("start_y", w_y, 0);
        check("start_fs", w_frame_start, 0);

        r_rgb_in = 12'hF00;
        run_to(2559);
        check("x639",       w_x, 639);
        check("vo_x639",    w_video_on, 1);
        tick();
        check("x640",       w_x, 640);
        check("vo_x640",    w_video_on, 0);
        check("rgb_x640",   w_rgb_out, 12'hF00);
        tick();
        check("rgb_blank",  w_rgb_out, 12'h000);
        check("hs_x640",    w_hsync, 1);

        hs_low   = 0;
        hs_first = -1;
        while (edge_n < 3195) begin
            tick();
            if (w_hsync == 1'b0) begin
                hs_low++;
                if (hs_first < 0) begin
                    hs_first = edge_n;
                    check("hs_first_x", w_x, 656);
                end
            end
        end
        check("hs_low_clks", hs_low, 384);
        check("hs_first_edge", hs_first, 2624);

        run_to(3196);
        check("x799", w_x, 799);
        check("y0_end", w_y, 0);
        run_to(3199);
        check("x799_hold", w_x, 799);
        tick();
        check("wrap_x", w_x, 0);
        check("wrap_y", w_y, 1);
        check("wrap_p_tick", w_p_tick, 1);
        check("wrap_vo", w_video_on, 1);
        check("wrap_fs", w_frame_start, 0);
        tick();
        check("rgb_reopen", w_rgb_out, 12'hF00);

        run_to(6399);
        check("l1_x", w_x, 799);
        check("l1_y", w_y, 1);
        tick();
        check("l2_x", w_x, 0);
        check("l2_y", w_y, 2);

        // Asynchronous reset during hsync low at x = 700
        run_to(9201);
        check("pre_rst_x",  w_x, 700);
        check("pre_rst_hs", w_hsync, 0);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("arst_hsync", w_hsync, 1);
        check("arst_x",     w_x, 0);
        check("arst_y",     w_y, 0);
        check("arst_rgb",   w_rgb_out, 12'h000);
        check("arst_vo",    w_video_on, 1);
        check("arst_ptick", w_p_tick, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        r_rst_n = 1'b1;
        edge_n  = 0;

        run_to(3);
        check("re_x3",     w_x, 0);
        check("re_ptick3", w_p_tick, 0);
        tick();
        check("re_x4",     w_x, 1);
        check("re_ptick4", w_p_tick, 1);
        check("re_fs4",    w_frame_start, 0);

        // Small instance: pixel p occupies edges 2p..2p+1.
        run_to(15);
        check("s_x7",   s_x, 7);
        check("s_vo7",  s_video_on, 1);
        tick();
        check("s_x8",   s_x, 8);
        check("s_vo8",  s_video_on, 0);

        vs_low   = 0;
        vs_first = -1;
        fs_cnt   = 0;
        fs_first = -1;
        while (edge_n < 500) begin
            tick();
            if (s_vsync == 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = edge_n;
            end
            if (s_frame_start == 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = edge_n;
            end
            if (edge_n == 19) check("s_hs_h9",  s_hsync, 1);
            if (edge_n == 20) check("s_hs_h10", s_hsync, 0);
            if (edge_n == 120) begin
                check("s_y4",    s_y, 4);
                check("s_vo_y4", s_video_on, 0);
            end
            if (edge_n == 122) check("s_rgb_y4", s_rgb_out, 12'h000);
            if (edge_n == 239) begin
                check("s_x_last", s_x, 14);
                check("s_y_last", s_y, 7);
                check("s_fs_pre", s_frame_start, 0);
            end
            if (edge_n == 240) begin
                check("s_x_wrap",  s_x, 0);
                check("s_y_wrap",  s_y, 0);
                check("s_pt_wrap", s_p_tick, 1);
                check("s_vo_wrap", s_video_on, 1);
            end
            if (edge_n == 241) check("s_fs_post", s_frame_start, 0);
        end
        check("s_vs_low_clks", vs_low, 120);
        check("s_vs_first",    vs_first, 150);
        check("s_fs_count",    fs_cnt, 2);
        check("s_fs_first",    fs_first, 240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
